// File: rtl/pdm_modulator.sv
// PCM-to-PDM playback: sample FIFO feeding a first-order sigma-delta modulator,
// one PCM sample consumed every OVERSAMPLE pdm_clk cycles.
module pdm_modulator #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned OVERSAMPLE  = 128,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PRIME_LEVEL = 2
) (
   input  logic                               pdm_clk,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic [DATA_WIDTH-1:0]              pcm_in,
   input  logic                               pcm_valid,
   output logic                               pcm_ready,
   output logic                               pdm_out,
   output logic                               sample_tick,
   output logic                               underrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PH_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PH_W-1:0]       phase;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] cur_sample;
   logic [DATA_WIDTH-1:0] u_c;
   logic [DATA_WIDTH:0]   sum_c;
   logic                  push_c;
   logic                  fetch_c;
   logic                  pop_c;
   logic                  miss_c;
   logic                  run_c;

   assign pcm_ready = enable && (fifo_level < LVL_W'(FIFO_DEPTH));

   // Next state, FIFO strobes and modulator sum
   always_comb begin
      state_nxt = state;
      push_c    = pcm_valid && pcm_ready;
      fetch_c   = enable && (state == ST_RUN) && (phase == '0);
      pop_c     = fetch_c && (fifo_level != '0);
      miss_c    = fetch_c && (fifo_level == '0);
      run_c     = enable && ((state == ST_PRIME) || (state == ST_RUN));
      u_c       = {~cur_sample[DATA_WIDTH-1], cur_sample[DATA_WIDTH-2:0]};
      sum_c     = {1'b0, acc} + {1'b0, u_c};
      case (state)
         ST_OFF:   state_nxt = ST_PRIME;
         ST_PRIME: if (fifo_level >= LVL_W'(PRIME_LEVEL)) state_nxt = ST_RUN;
         ST_RUN:   state_nxt = ST_RUN;
         default:  state_nxt = ST_OFF;
      endcase
      if (!enable) state_nxt = ST_OFF;
   end

   always_ff @(posedge pdm_clk or negedge rst_n) begin
      if (!rst_n) state <= ST_OFF;
      else        state <= state_nxt;
   end

   // FIFO pointers and occupancy; dropping enable discards the contents
   always_ff @(posedge pdm_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else if (!enable) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_c && !pop_c)      fifo_level <= fifo_level + LVL_W'(1);
         else if (pop_c && !push_c) fifo_level <= fifo_level - LVL_W'(1);
      end
   end

   always_ff @(posedge pdm_clk) begin
      if (push_c) mem[wr_ptr] <= pcm_in;
   end

   // Sigma-delta core: the accumulator carries its residue across samples
   always_ff @(posedge pdm_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         phase       <= '0;
         cur_sample  <= '0;
         pdm_out     <= 1'b0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
      end else if (!run_c) begin
         acc         <= '0;
         phase       <= '0;
         cur_sample  <= '0;
         pdm_out     <= 1'b0;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         acc         <= sum_c[DATA_WIDTH-1:0];
         pdm_out     <= sum_c[DATA_WIDTH];
         sample_tick <= pop_c;
         underrun    <= miss_c;
         if (state == ST_RUN)
            phase <= (phase == PH_W'(OVERSAMPLE - 1)) ? '0 : phase + PH_W'(1);
         else
            phase <= '0;
         if (pop_c) cur_sample <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: vector table, density windows,
// corner sequences and randomized traffic against a queue/integer reference model.
module tb_pdm_modulator;

   localparam int DW    = 16;
   localparam int OS    = 128;
   localparam int DEPTH = 4;
   localparam int PLVL  = 2;

   logic        pdm_clk;
   logic        rst_n;
   logic        enable;
   logic [15:0] pcm_in;
   logic        pcm_valid;
   logic        pcm_ready;
   logic        pdm_out;
   logic        sample_tick;
   logic        underrun;
   logic [2:0]  fifo_level;

   logic        en_p;
   logic [15:0] din_p;
   logic        valid_p;
   logic        ready_p;
   logic        pdm_p;
   logic        tick_p;
   logic        und_p;
   logic [2:0]  level_p;

   pdm_modulator #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PLVL)) dut (
      .pdm_clk(pdm_clk), .rst_n(rst_n), .enable(enable), .pcm_in(pcm_in),
      .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .pdm_out(pdm_out),
      .sample_tick(sample_tick), .underrun(underrun), .fifo_level(fifo_level));

   pdm_modulator #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(DEPTH)) dut_p (
      .pdm_clk(pdm_clk), .rst_n(rst_n), .enable(en_p), .pcm_in(din_p),
      .pcm_valid(valid_p), .pcm_ready(ready_p), .pdm_out(pdm_p),
      .sample_tick(tick_p), .underrun(und_p), .fifo_level(level_p));

   initial pdm_clk = 1'b0;
   always #5 pdm_clk = ~pdm_clk;

   int checks   = 0;
   int failures = 0;
   int ones, ticks, unds;
   logic last_ready, last_ready_p;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: sample queue, integer accumulator, slot counter
   typedef enum {M_IDLE, M_SILENT, M_PLAY} mmode_t;
   mmode_t      m_mode;
   logic [15:0] mq[$];
   int          m_acc, m_cur, m_slot;
   logic        m_pdm, m_tick, m_und;

   function automatic void model_clear();
      m_mode = M_IDLE;
      mq.delete();
      m_acc = 0; m_cur = 0; m_slot = 0;
      m_pdm = 1'b0; m_tick = 1'b0; m_und = 1'b0;
   endfunction

   function automatic void model_step(input logic e, input logic v, input logic [15:0] d,
                                      input logic rdy);
      logic [15:0] head;
      int          nxt_cur;
      if (!e) begin
         model_clear();
         return;
      end
      if (m_mode == M_IDLE) begin
         model_clear();
         m_mode = M_SILENT;
         if (v && rdy) mq.push_back(d);
         return;
      end
      m_acc = m_acc + m_cur + 32768;
      m_pdm = (m_acc >= 65536);
      if (m_pdm) m_acc -= 65536;
      m_tick  = 1'b0;
      m_und   = 1'b0;
      nxt_cur = m_cur;
      if (m_mode == M_PLAY) begin
         if (m_slot == 0) begin
            if (mq.size() > 0) begin
               head    = mq.pop_front();
               nxt_cur = int'($signed(head));
               m_tick  = 1'b1;
            end else begin
               m_und = 1'b1;
            end
         end
         m_slot = (m_slot + 1) % OS;
      end else if (mq.size() >= PLVL) begin
         m_mode = M_PLAY;
         m_slot = 0;
      end
      if (v && rdy) mq.push_back(d);
      m_cur = nxt_cur;
   endfunction

   // One clock: drive at negedge, check ready pre-edge, check registered outputs at next negedge
   task automatic step(input logic e, input logic v, input logic [15:0] d);
      logic m_ready;
      enable    = e;
      pcm_valid = v;
      pcm_in    = d;
      m_ready   = e && (mq.size() < DEPTH);
      #1;
      last_ready   = pcm_ready;
      last_ready_p = ready_p;
      chk("pcm_ready", 32'(pcm_ready), 32'(m_ready));
      @(posedge pdm_clk);
      model_step(e, v, d, m_ready);
      @(negedge pdm_clk);
      chk("pdm_out", 32'(pdm_out), 32'(m_pdm));
      chk("sample_tick", 32'(sample_tick), 32'(m_tick));
      chk("underrun", 32'(underrun), 32'(m_und));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      ones  += int'(pdm_out);
      ticks += int'(sample_tick);
      unds  += int'(underrun);
   endtask

   task automatic clr_counts();
      ones = 0; ticks = 0; unds = 0;
   endtask

   typedef struct {
      logic        en;
      logic        valid;
      logic [15:0] data;
      logic        exp_ready;
      logic [2:0]  exp_level;
      logic        exp_pdm;
      logic        exp_tick;
   } vec_t;
   vec_t tbl[11];

   logic        p_valid [9];
   logic [15:0] p_data  [9];
   logic        p_rdy   [9];
   logic [2:0]  p_lvl   [9];
   logic        p_pdm   [9];
   logic        p_tick  [9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc_p;
      logic found;
      int   off_cnt;
      logic e, v;
      logic [15:0] d;

      tbl[0]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 3'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 3'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 16'h4000, 1'b1, 3'd1, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 16'hC000, 1'b1, 3'd2, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b1, 1'b1};

      p_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      p_data  = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000,
                  16'h5000, 16'h5000, 16'h5000, 16'h0000};
      p_rdy   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      p_lvl   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4, 3'd4};
      p_pdm   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      p_tick  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0; enable = 1'b0; pcm_valid = 1'b1; pcm_in = 16'h1111;
      en_p = 1'b0; valid_p = 1'b0; din_p = 16'h0;
      model_clear();
      clr_counts();
      repeat (2) @(negedge pdm_clk);
      chk("rst_pdm_out", 32'(pdm_out), 32'd0);
      chk("rst_pcm_ready", 32'(pcm_ready), 32'd0);
      chk("rst_fifo_level", 32'(fifo_level), 32'd0);
      chk("rst_sample_tick", 32'(sample_tick), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      rst_n = 1'b1;

      // Hand-derived vectors: idle, PRIME silence pattern, fill, promotion, first pop
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].en, tbl[i].valid, tbl[i].data);
         chk($sformatf("vec%0d_ready", i), 32'(last_ready), 32'(tbl[i].exp_ready));
         chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].exp_level));
         chk($sformatf("vec%0d_pdm", i), 32'(pdm_out), 32'(tbl[i].exp_pdm));
         chk($sformatf("vec%0d_tick", i), 32'(sample_tick), 32'(tbl[i].exp_tick));
      end

      // Density windows: 0x4000, then 0xC000, then underrun with held sample
      clr_counts();
      repeat (OS) step(1'b1, 1'b0, 16'h0);
      chk("win_4000_ones", 32'(ones), 32'd96);
      chk("win_4000_ticks", 32'(ticks), 32'd1);
      chk("win_4000_underruns", 32'(unds), 32'd0);
      clr_counts();
      repeat (OS) step(1'b1, 1'b0, 16'h0);
      chk("win_c000_ones", 32'(ones), 32'd32);
      chk("win_c000_ticks", 32'(ticks), 32'd0);
      chk("win_c000_underruns", 32'(unds), 32'd1);
      clr_counts();
      repeat (OS) step(1'b1, 1'b0, 16'h0);
      chk("win_hold_ones", 32'(ones), 32'd32);
      chk("win_hold_ticks", 32'(ticks), 32'd0);
      chk("win_hold_underruns", 32'(unds), 32'd1);

      // Disable mid-window with data queued, then re-enable into PRIME
      step(1'b1, 1'b1, 16'h1234);
      step(1'b1, 1'b1, 16'h5678);
      repeat (20) step(1'b1, 1'b0, 16'h0);
      chk("pre_off_level", 32'(fifo_level), 32'd2);
      step(1'b0, 1'b0, 16'h0);
      chk("off_pdm", 32'(pdm_out), 32'd0);
      chk("off_level", 32'(fifo_level), 32'd0);
      chk("off_ready", 32'(last_ready), 32'd0);
      step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 16'h8000);
      chk("reprime_bit0", 32'(pdm_out), 32'd0);
      step(1'b1, 1'b1, 16'h7FFF);
      chk("reprime_bit1", 32'(pdm_out), 32'd1);

      // Full-scale negative then positive
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         step(1'b1, 1'b0, 16'h0);
         if (sample_tick) found = 1'b1;
      end
      chk("fs_tick_seen", 32'(found), 32'd1);
      clr_counts();
      repeat (OS) step(1'b1, 1'b0, 16'h0);
      chk("fs_neg_ones", 32'(ones), 32'd0);
      chk("fs_neg_ticks", 32'(ticks), 32'd1);
      clr_counts();
      repeat (OS) step(1'b1, 1'b0, 16'h0);
      chk("fs_pos_ones_ge127", 32'(ones >= 127), 32'd1);

      // PRIME_LEVEL == FIFO_DEPTH instance: five back-to-back pushes
      acc_p = 0;
      for (int i = 0; i < 9; i++) begin
         en_p    = 1'b1;
         valid_p = p_valid[i];
         din_p   = p_data[i];
         step(1'b0, 1'b0, 16'h0);
         if (last_ready_p && valid_p) acc_p++;
         chk($sformatf("p%0d_ready", i), 32'(last_ready_p), 32'(p_rdy[i]));
         chk($sformatf("p%0d_level", i), 32'(level_p), 32'(p_lvl[i]));
         chk($sformatf("p%0d_tick", i), 32'(tick_p), 32'(p_tick[i]));
         chk($sformatf("p%0d_underrun", i), 32'(und_p), 32'd0);
         if (i <= 6) chk($sformatf("p%0d_pdm", i), 32'(pdm_p), 32'(p_pdm[i]));
         if (i == 5) chk("p_accepted_before_pop", 32'(acc_p), 32'd4);
      end
      chk("p_accepted_total", 32'(acc_p), 32'd5);
      en_p = 1'b0; valid_p = 1'b0;

      // Randomized traffic against the model
      off_cnt = 0;
      for (int i = 0; i < 6000; i++) begin
         if (off_cnt > 0) begin
            e = 1'b0;
            off_cnt--;
         end else begin
            e = 1'b1;
            if ($urandom_range(0, 999) == 0) off_cnt = $urandom_range(1, 5);
         end
         v = ($urandom_range(0, 99) < 2);
         case ($urandom_range(0, 3))
            0:       d = 16'h8000;
            1:       d = 16'h7FFF;
            default: d = 16'($urandom);
         endcase
         step(e, v, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
